// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and elaboration helpers for the LFSR generator
package lfsr_pkg;

    localparam int LFSR_FIBONACCI = 0;
    localparam int LFSR_GALOIS    = 1;

    // Reverse the low w bits of v; the Galois feedback mask is the mirrored Fibonacci tap set
    function automatic logic [63:0] bitrev(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) begin
                r[6'(w - 1 - i)] = v[6'(i)];
            end
        end
        return r;
    endfunction

    // True when the parameter set describes a usable generator
    function automatic bit params_ok(input int width, input logic [63:0] taps,
                                     input logic [63:0] seed, input int steps,
                                     input int galois);
        return (width >= 3) && (width <= 64) && (taps[6'(width - 1)] == 1'b1) &&
               (seed != 64'd0) && (steps >= 1) && (steps <= width) &&
               ((galois == LFSR_FIBONACCI) || (galois == LFSR_GALOIS));
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one combinational LFSR shift in Fibonacci or Galois form
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter int               GALOIS = LFSR_FIBONACCI
) (
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] f
);

    // Galois mask realises the same polynomial as the Fibonacci taps
    localparam logic [WIDTH-1:0] GMASK = WIDTH'(bitrev(64'(TAPS), WIDTH));

    if (GALOIS == LFSR_GALOIS) begin : g_galois
        assign f = {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & GMASK);
    end else begin : g_fibonacci
        assign f = {s[WIDTH-2:0], ^(s & TAPS)};
    end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - LFSR word generator with valid/ready output, seed load and lockup guard
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter logic [WIDTH-1:0] SEED   = 8'h01,
    parameter int               GALOIS = LFSR_FIBONACCI,
    parameter int               STEPS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap,
    output logic             lockup
);

    if (!params_ok(WIDTH, 64'(TAPS), 64'(SEED), STEPS, GALOIS)) begin : g_bad_params
        $error("lfsr_gen: illegal WIDTH/TAPS/SEED/STEPS/GALOIS combination");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_state;
    logic             xfer;

    // STEPS chained single-step stages; each stage owns its own output net
    for (genvar g = 0; g < STEPS; g++) begin : g_stage
        logic [WIDTH-1:0] s_out;
        if (g == 0) begin : g_first
            lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .GALOIS(GALOIS)) u_step (
                .s (state_q),
                .f (s_out)
            );
        end else begin : g_rest
            lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .GALOIS(GALOIS)) u_step (
                .s (g_stage[g-1].s_out),
                .f (s_out)
            );
        end
    end

    assign next_state = g_stage[STEPS-1].s_out;
    assign xfer       = valid_q & out_ready;

    // Next state: load beats transfer; a zero seed or zero state recovers to SEED
    always_comb begin
        state_d  = state_q;
        valid_d  = en | (valid_q & ~out_ready);
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            if (load_data == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = load_data;
            end
        end else if (state_q == '0) begin
            state_d  = SEED;
            lockup_d = 1'b1;
        end else if (xfer) begin
            state_d = next_state;
            wrap_d  = (next_state == SEED);
        end
    end

    // State and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_data  = state_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen across four configurations
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset, en, load, out_ready;
    logic [7:0] load_data;

    logic [7:0] f_data, g_data, s_data;
    logic [3:0] w_data;
    logic       f_valid, g_valid, s_valid, w_valid;
    logic       f_wrap, g_wrap, s_wrap, w_wrap;
    logic       f_lock, g_lock, s_lock, w_lock;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q_f[$];
    logic [7:0] q_g[$];
    logic [7:0] q_s[$];
    int         w_xfers = 0;
    int         w_wraps = 0;
    logic [15:0] w_seen = '0;
    bit         w_zero  = 1'b0;
    bit         w_track = 1'b0;
    logic [7:0] v;

    always #5 clk = ~clk;

    lfsr_gen u_fib (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_data(load_data),
        .out_data(f_data), .out_valid(f_valid), .out_ready(out_ready),
        .wrap(f_wrap), .lockup(f_lock)
    );

    lfsr_gen #(.GALOIS(1)) u_gal (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_data(load_data),
        .out_data(g_data), .out_valid(g_valid), .out_ready(out_ready),
        .wrap(g_wrap), .lockup(g_lock)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) u_w4 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_data(load_data[3:0]),
        .out_data(w_data), .out_valid(w_valid), .out_ready(out_ready),
        .wrap(w_wrap), .lockup(w_lock)
    );

    lfsr_gen #(.STEPS(8)) u_s8 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_data(load_data),
        .out_data(s_data), .out_valid(s_valid), .out_ready(out_ready),
        .wrap(s_wrap), .lockup(s_lock)
    );

    // Reference x^8+x^6+x^5+x^4+1 Fibonacci step with taps 7,5,4,3
    function automatic logic [7:0] fib8(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Score words taken this cycle, then advance one clock
    task automatic step();
        if (f_valid && out_ready && q_f.size() > 0) chk("fib_seq", 64'(f_data), 64'(q_f.pop_front()));
        if (g_valid && out_ready && q_g.size() > 0) chk("gal_seq", 64'(g_data), 64'(q_g.pop_front()));
        if (s_valid && out_ready && q_s.size() > 0) chk("steps8_seq", 64'(s_data), 64'(q_s.pop_front()));
        if (w_track) begin
            if (w_wrap) begin
                w_wraps++;
                chk("w4_wrap_phase", 64'(w_xfers % 15), 64'd0);
            end
            if (w_valid && out_ready) begin
                w_xfers++;
                if (w_xfers <= 15) w_seen[w_data] = 1'b1;
                if (w_data == 4'h0) w_zero = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        load_data = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(f_valid), 64'd0);
        chk("rst_data", 64'(f_data), 64'h01);
        chk("rst_wrap", 64'(f_wrap), 64'd0);
        chk("rst_lockup", 64'(f_lock), 64'd0);
        chk("rst_w4_data", 64'(w_data), 64'h1);

        q_f = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
        q_g = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD};
        v = 8'h01;
        for (int k = 0; k < 4; k++) begin
            q_s.push_back(v);
            for (int j = 0; j < 8; j++) v = fib8(v);
        end

        reset     = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        step();
        chk("valid_rise", 64'(f_valid), 64'd1);
        chk("steps8_first", 64'(s_data), 64'h01);

        w_track = 1'b1;
        for (int i = 0; i < 45; i++) begin
            out_ready = !(i >= 3 && i < 8);
            if (!out_ready) begin
                chk("stall_data", 64'(f_data), 64'h08);
                chk("stall_valid", 64'(f_valid), 64'd1);
            end
            step();
        end
        w_track = 1'b0;
        chk("fib_q_drained", 64'(q_f.size()), 64'd0);
        chk("gal_q_drained", 64'(q_g.size()), 64'd0);
        chk("steps8_q_drained", 64'(q_s.size()), 64'd0);
        chk("w4_wrap_count", 64'(w_wraps), 64'(w_xfers / 15));
        chk("w4_wrap_min", 64'(w_wraps >= 2), 64'd1);
        chk("w4_all_values", 64'(w_seen), 64'hFFFE);
        chk("w4_no_zero", 64'(w_zero), 64'd0);

        out_ready = 1'b1;
        reset     = 1'b1;
        step();
        chk("midrst_data", 64'(f_data), 64'h01);
        chk("midrst_valid", 64'(f_valid), 64'd0);
        chk("midrst_steps8", 64'(s_data), 64'h01);
        reset = 1'b0;
        step();
        chk("midrst_valid_back", 64'(f_valid), 64'd1);

        step();
        chk("adv_before_load", 64'(f_data), 64'h02);
        load      = 1'b1;
        load_data = 8'h00;
        step();
        load      = 1'b0;
        out_ready = 1'b0;
        chk("zero_load_data", 64'(f_data), 64'h01);
        chk("zero_load_lockup", 64'(f_lock), 64'd1);
        chk("zero_load_nowrap", 64'(f_wrap), 64'd0);
        step();
        chk("lockup_one_cycle", 64'(f_lock), 64'd0);

        load      = 1'b1;
        load_data = 8'h5A;
        out_ready = 1'b1;
        step();
        load = 1'b0;
        chk("load_data", 64'(f_data), 64'h5A);
        chk("load_nowrap", 64'(f_wrap), 64'd0);
        chk("load_nolockup", 64'(f_lock), 64'd0);
        chk("load_valid", 64'(f_valid), 64'd1);
        step();
        chk("after_load_step", 64'(f_data), 64'(fib8(8'h5A)));

        en        = 1'b0;
        out_ready = 1'b0;
        step();
        chk("en_off_pending_valid", 64'(f_valid), 64'd1);
        chk("en_off_pending_data", 64'(f_data), 64'(fib8(8'h5A)));
        out_ready = 1'b1;
        step();
        chk("en_off_drain_valid", 64'(f_valid), 64'd0);
        chk("en_off_drain_data", 64'(f_data), 64'(fib8(fib8(8'h5A))));
        step();
        chk("en_off_frozen", 64'(f_data), 64'(fib8(fib8(8'h5A))));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
